// File: rtl/lsu_subword.sv
// Sub-word load/store unit in front of a word-only memory.
// Loads extract and extend a lane; SH/SB do read-modify-write of the containing word.
module lsu_subword (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  memwrite,
    input  logic        half,
    input  logic        b,
    input  logic        bunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SW   = 2'b01,
        OP_SH   = 2'b10,
        OP_SB   = 2'b11
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        half_q, half_d;
    logic        b_q, b_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wword_q, wword_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    function automatic logic is_illegal(input op_t op, input logic h, input logic by,
                                        input logic [1:0] a);
        logic ill;
        ill = 1'b0;
        unique case (op)
            OP_LOAD: begin
                if (h && by)  ill = 1'b1;
                else if (h)   ill = a[0];
                else if (!by) ill = (a != 2'b00);
            end
            OP_SW:   ill = (a != 2'b00);
            OP_SH:   ill = a[0];
            OP_SB:   ill = 1'b0;
        endcase
        return ill;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic h, input logic by,
                                                 input logic uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {a, 3'b000};
        if (by) begin
            res = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        end else if (h) begin
            res = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Replicate the store data across all lanes, then let a shifted mask pick the addressed one.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input op_t op,
                                                input logic [1:0] a, input logic [15:0] d);
        logic [31:0] mask;
        logic [31:0] data;
        if (op == OP_SB) begin
            mask = 32'h0000_00FF << {a, 3'b000};
            data = {4{d[7:0]}};
        end else begin
            mask = 32'h0000_FFFF << {a[1], 4'b0000};
            data = {2{d}};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        half_d  = half_q;
        b_d     = b_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = op_t'(memwrite);
                    half_d  = half;
                    b_d     = b;
                    uns_d   = bunsigned;
                    addr_d  = addr;
                    wword_d = wdata;
                    rdata_d = '0;
                    err_d   = is_illegal(op_t'(memwrite), half, b, addr[1:0]);
                    if (err_d)
                        state_d = RESP;
                    else if (op_t'(memwrite) == OP_SW)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                if (mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        rdata_d = load_extract(mem_rdata, addr_q[1:0], half_q, b_q, uns_q);
                        state_d = RESP;
                    end else begin
                        wword_d = merge_store(mem_rdata, op_q, addr_q[1:0], wword_q[15:0]);
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (mem_ack)
                    state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_req    = (state_q == RD) || (state_q == WR);
        mem_we     = (state_q == WR);
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
        mem_wdata  = mem_we ? wword_q : '0;
        resp_valid = (state_q == RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid && err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            half_q  <= 1'b0;
            b_q     <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            half_q  <= half_d;
            b_q     <= b_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword: table of single ops against a wait-state memory model,
// plus hand sequences for reset, priority and back-to-back traffic.
module tb_lsu_subword;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  memwrite;
    logic        half;
    logic        b;
    logic        bunsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    lsu_subword dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .memwrite   (memwrite),
        .half       (half),
        .b          (b),
        .bunsigned  (bunsigned),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        half;
        logic        b;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives one op, plays a memory with v.waits stall cycles per access, checks the response.
    task automatic run_op(input vec_t v, input int idx);
        int c;
        int wcnt;
        int nrd;
        int nwr;
        int lat;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_maddr;
        exp_maddr = {v.addr[31:2], 2'b00};
        wcnt = v.waits;
        nrd = 0;
        nwr = 0;
        lat = -1;
        wd = '0;
        rd = '0;
        er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        memwrite  = v.op;
        half      = v.half;
        b         = v.b;
        bunsigned = v.uns;
        addr      = v.addr;
        wdata     = v.wdata;
        mem_ack   = 1'b0;
        chk($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        c = 1;
        while (c < 50) begin
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            if (mem_req) begin
                if (wcnt > 0) begin
                    mem_ack = 1'b0;
                    wcnt--;
                end else begin
                    mem_ack = 1'b1;
                    chk($sformatf("v%0d mem_addr", idx), mem_addr, exp_maddr);
                    if (mem_we) begin
                        nwr++;
                        wd = mem_wdata;
                    end else begin
                        nrd++;
                        mem_rdata = v.mword;
                    end
                    wcnt = v.waits;
                end
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        mem_ack = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d resp_rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d resp_err", idx), {31'b0, er}, {31'b0, v.exp_err});
        chk($sformatf("v%0d reads", idx), nrd, v.exp_rd);
        chk($sformatf("v%0d writes", idx), nwr, v.exp_wr);
        if (v.exp_wr != 0)
            chk($sformatf("v%0d write word", idx), wd, v.exp_wdata);
        @(negedge clk);
        chk($sformatf("v%0d resp pulse", idx), {31'b0, resp_valid}, 32'd0);
        chk($sformatf("v%0d ready again", idx), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int          t1;
        int          t2;
        int          nresp;
        int          nacc;
        int          rr_bad;
        logic        acc;
        logic [31:0] rd2;
        logic [31:0] bmem;
        vec_t        sw300;

        //         op     h     b     u     addr        wdata          mword          w  rdata          e     lat rd wr wword
        vecs[0]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0,          32'h80FF7F01, 0, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h0};
        vecs[1]  = '{2'b00, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0,          32'h80FF7F01, 0, 32'h000080FF, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0,          32'h80FF7F01, 0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0,          32'h80FF7F01, 0, 32'h00000080, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0,          32'h80FF7F01, 0, 32'h0000007F, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0,          32'h80FF7F01, 2, 32'h00000001, 1'b0, 4, 1, 0, 32'h0};
        vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,          32'h80FF7F01, 1, 32'h80FF7F01, 1'b0, 3, 1, 0, 32'h0};
        vecs[7]  = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,          32'h80FF7F01, 0, 32'h00007F01, 1'b0, 2, 1, 0, 32'h0};
        vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h104, 32'hDEADBEEF,   32'h0,        0, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h201, 32'hFFFFFFAB,   32'h11223344, 2, 32'h0,        1'b0, 7, 1, 1, 32'h1122AB44};
        vecs[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h202, 32'h1234CAFE,   32'h11223344, 0, 32'h0,        1'b0, 3, 1, 1, 32'hCAFE3344};
        vecs[11] = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h203, 32'h00000055,   32'h11223344, 0, 32'h0,        1'b0, 3, 1, 1, 32'h55223344};
        vecs[12] = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0000BEEF,   32'hAABBCCDD, 1, 32'h0,        1'b0, 5, 1, 1, 32'hAABBBEEF};
        vecs[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h006, 32'h0,          32'h12345678, 0, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[14] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0,          32'h12345678, 0, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[15] = '{2'b00, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0,          32'h12345678, 0, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[16] = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h102, 32'h11111111,   32'h12345678, 0, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[17] = '{2'b10, 1'b0, 1'b0, 1'b0, 32'h203, 32'h2222,       32'h12345678, 0, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vecs[18] = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h108, 32'hCAFEF00D,   32'h0,        3, 32'h0,        1'b0, 5, 0, 1, 32'hCAFEF00D};

        reset     = 1'b1;
        req_valid = 1'b0;
        memwrite  = 2'b00;
        half      = 1'b0;
        b         = 1'b0;
        bunsigned = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 19; i++)
            run_op(vecs[i], i);

        // A stray ack while idle must not start anything.
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle ack resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("idle ack mem_req", {31'b0, mem_req}, 32'd0);
        chk("idle ack req_ready", {31'b0, req_ready}, 32'd1);

        // Reset wins over a simultaneous accept.
        reset     = 1'b1;
        req_valid = 1'b1;
        memwrite  = 2'b01;
        addr      = 32'h500;
        wdata     = 32'h5;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        chk("rst prio mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst prio req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("rst prio no op", {30'b0, mem_req, resp_valid}, 32'd0);

        // Reset while an SH is stalled in its write phase.
        req_valid = 1'b1;
        memwrite  = 2'b10;
        addr      = 32'h302;
        wdata     = 32'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req && mem_we) begin
                mem_ack = 1'b0;
                acc = 1'b1;
                break;
            end
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h01020304;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        chk("sh reached WR", {31'b0, acc}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid rst resp_valid", {31'b0, resp_valid}, 32'd0);
        nresp = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || mem_req) nresp++;
            @(negedge clk);
        end
        chk("mid rst quiet", nresp, 0);
        chk("mid rst req_ready", {31'b0, req_ready}, 32'd1);
        sw300 = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h300, 32'h600DCAFE, 32'h0, 0, 32'h0, 1'b0, 2, 0, 1, 32'h600DCAFE};
        run_op(sw300, 100);

        // SW then LW to the same word with req_valid held high throughout.
        @(negedge clk);
        req_valid = 1'b1;
        memwrite  = 2'b01;
        half      = 1'b0;
        b         = 1'b0;
        addr      = 32'h400;
        wdata     = 32'h0BADF00D;
        bmem      = 32'h0;
        nresp = 0;
        nacc = 0;
        rr_bad = 0;
        t1 = -1;
        t2 = -1;
        rd2 = '0;
        for (int cyc = 0; cyc < 20 && nresp < 2; cyc++) begin
            if (req_ready == (mem_req || resp_valid)) rr_bad++;
            if (mem_req) begin
                mem_ack = 1'b1;
                if (mem_we) bmem = mem_wdata;
                else        mem_rdata = bmem;
            end else begin
                mem_ack = 1'b0;
            end
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) t1 = cyc;
                else begin
                    t2  = cyc;
                    rd2 = resp_rdata;
                end
            end
            acc = req_valid && req_ready;
            @(negedge clk);
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    memwrite = 2'b00;
                    wdata    = 32'h0;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        chk("b2b responses", nresp, 2);
        chk("b2b SW resp cycle", t1, 2);
        chk("b2b LW resp cycle", t2, 5);
        chk("b2b LW data", rd2, 32'h0BADF00D);
        chk("b2b mem word", bmem, 32'h0BADF00D);
        chk("b2b ready violations", rr_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
